rgb_pwm_fader: RTL and testbench
================================

# rgb_pwm_fader

Per-channel PWM driver for the board RGB LED with a command handshake and a linear fade engine. It takes 24-bit colour commands from a sequencer, applies them only at PWM period boundaries so there are no glitches, and ramps each channel toward its target level one step at a time. Its outputs drive the LED pins directly, which are active-low.

## Interface
- P_PRESCALE, 16: clock cycles per PWM tick (≥2).
- P_FADE_DIV, 64: PWM periods per fade step (≥1).
- P_ACTIVE_LOW, 1: when 1, an LED that is on drives 0.
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  command valid.
- o_ready  out  1  command slot free.
- i_rgb  in  24  target levels: [23:16] R, [15:8] G, [7:0] B.
- i_fade  in  1  1 = ramp to target, 0 = jump to target.
- o_led_r, o_led_g, o_led_b  out  1 each  registered PWM outputs.
- o_busy  out  1  some channel has current level ≠ target.
- o_period  out  1  one-cycle pulse at each period boundary.

## Operation
- Prescaler counts 0..P_PRESCALE-1. tick = (prescaler == P_PRESCALE-1).
- 8-bit pwm_cnt increments on tick and wraps 255→0. One period = 256 ticks = 256·P_PRESCALE clocks.
- Boundary = the edge on which pwm_cnt wraps 255→0.
- Each channel x holds two 8-bit levels: cur_x and tgt_x.
  - lit_x = (pwm_cnt < cur_x).
  - o_led_x <= lit_x ^ P_ACTIVE_LOW.
  - Level 0 is always off; level 255 is on for 255 of 256 ticks.
- Command slot is one pending register {rgb, fade}, and o_ready = slot empty.
  - A transfer occurs when i_valid && o_ready. The command is captured, and o_ready = 0 from the next cycle.
  - i_rgb and i_fade are ignored when no transfer occurs.
- Apply at a boundary with the slot full:
  - tgt <= pending.rgb.
  - If fade = 0, cur <= pending.rgb as well.
  - Slot cleared, so o_ready = 1 on the next cycle.
- Fade divider counts boundaries modulo P_FADE_DIV. When it wraps, that boundary is a step boundary. On a step boundary, each cur_x moves ±1 toward tgt_x, and is unchanged if equal.
- Simultaneous events:
  - When apply and a step boundary coincide, apply wins and no step occurs that boundary. The divider still advances.
  - A command arriving mid-fade retargets. The fade continues from the present cur.
- o_busy = |(cur ≠ tgt), registered.

## Timing
- Reset (i_rst high at an edge):
  - prescaler, pwm_cnt, fade divider, all cur and tgt cleared to 0; slot emptied.
  - o_led_x = P_ACTIVE_LOW.
  - o_busy = 0, o_period = 0.
  - o_ready = 0 while i_rst is high, and 1 on the first cycle after release.
- Reset mid-operation drops the pending command and any fade in progress. LEDs are off on the next cycle.
- Command latency:
  - Acceptance to apply is at most one period plus one cycle.
  - cur/tgt update on the boundary edge B.
  - The o_led_x change is visible from edge B+1, since the output register adds one cycle.
- o_period is high for exactly the cycle after edge B. It pulses every period, with or without a command.
- Jump commands change the duty cycle only at a boundary, so no partial period occurs.
- Full fade 0→255 takes 255·P_FADE_DIV periods.
- Arithmetic is unsigned 8-bit. cur never overshoots tgt and never wraps.

## Test plan
Bench uses P_PRESCALE=2, P_FADE_DIV=2, P_ACTIVE_LOW=1, giving a 512-clock period.

- Reset:
  - Stimulus: hold i_rst for 3 cycles, then release.
  - Required: during reset, o_led_{r,g,b}=1, o_ready=0, o_busy=0. After release, o_ready=1, and o_period pulses every 512 clocks.
- Jump:
  - Stimulus: send 0x80_00_FF with fade=0.
  - Required: o_ready=0 until the boundary, and o_busy stays 0.
  - Required per period afterwards: o_led_r low for 256 clocks, o_led_g always high, o_led_b low for 510 clocks.
- Fade up:
  - Stimulus: send 0x04_00_00 with fade=1.
  - Required: o_busy=1 after apply. cur_r reaches 1, 2, 3, 4 at successive step boundaries (every 2 periods). o_busy drops after cur_r=4, and red on-time ends at 8 clocks per period.
- Backpressure:
  - Stimulus: hold i_valid with 0x11_22_33 while the slot is full, and change i_rgb to 0xFF_FF_FF before o_ready rises.
  - Required: only the value present at the cycle o_ready=1 is captured. The earlier value has no effect.
- Retarget mid-fade:
  - Stimulus: fade 0→0x0A, then at cur=5 send 0x02 with fade=1.
  - Required: cur steps 5→4→3→2, with no step on the apply boundary. o_busy falls at 2.
- Reset mid-fade:
  - Stimulus: assert i_rst for 1 cycle while o_busy=1 and a command is pending.
  - Required: on the next cycle, all LEDs are 1 and o_busy=0. The pending command is never applied.

Source files
------------

// File: rtl/rgb_pwm_fader.sv
// Three-channel PWM driver for the board RGB LED with a one-deep command slot and a linear fade engine.
// New levels take effect only at PWM period boundaries, so a period is never cut short or glitched.
module rgb_pwm_fader #(
   parameter int P_PRESCALE   = 16,
   parameter int P_FADE_DIV   = 64,
   parameter bit P_ACTIVE_LOW = 1'b1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [23:0] i_rgb,
   input  logic        i_fade,
   output logic        o_led_r,
   output logic        o_led_g,
   output logic        o_led_b,
   output logic        o_busy,
   output logic        o_period
);

   localparam int PW = (P_PRESCALE > 1) ? $clog2(P_PRESCALE) : 1;
   localparam int FW = (P_FADE_DIV > 1) ? $clog2(P_FADE_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(P_PRESCALE - 1);
   localparam logic [FW-1:0] FDIV_LAST  = FW'(P_FADE_DIV - 1);

   logic [PW-1:0]      presc_q, presc_d;
   logic [7:0]         pwm_cnt_q, pwm_cnt_d;
   logic [FW-1:0]      fdiv_q, fdiv_d;
   logic               pend_vld_q, pend_vld_d;
   logic [23:0]        pend_rgb_q, pend_rgb_d;
   logic               pend_fade_q, pend_fade_d;
   logic [2:0][7:0]    cur_q, cur_d;
   logic [2:0][7:0]    tgt_q, tgt_d;
   logic [2:0]         led_q, led_d;
   logic               busy_q, busy_d;
   logic               period_q, period_d;

   logic               tick;
   logic               boundary;
   logic               step;
   logic               apply;
   logic               xfer;

   // Slot is closed while reset is held so nothing is captured during reset.
   assign o_ready = ~pend_vld_q & ~i_rst;

   always_comb begin
      tick     = (presc_q == PRESC_LAST);
      boundary = tick && (pwm_cnt_q == 8'hFF);
      step     = boundary && (fdiv_q == FDIV_LAST);
      apply    = boundary && pend_vld_q;
      xfer     = i_valid && o_ready;

      presc_d   = tick ? '0 : presc_q + PW'(1);
      pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;

      fdiv_d = fdiv_q;
      if (boundary) begin
         fdiv_d = (fdiv_q == FDIV_LAST) ? '0 : fdiv_q + FW'(1);
      end

      pend_vld_d  = pend_vld_q;
      pend_rgb_d  = pend_rgb_q;
      pend_fade_d = pend_fade_q;
      if (apply) begin
         pend_vld_d = 1'b0;
      end
      if (xfer) begin
         pend_vld_d  = 1'b1;
         pend_rgb_d  = i_rgb;
         pend_fade_d = i_fade;
      end

      // Channel 0 is red, taken from the top byte of the command.
      for (int c = 0; c < 3; c++) begin
         cur_d[c] = cur_q[c];
         tgt_d[c] = tgt_q[c];
         if (apply) begin
            tgt_d[c] = pend_rgb_q[8*(2-c) +: 8];
            if (!pend_fade_q) begin
               cur_d[c] = pend_rgb_q[8*(2-c) +: 8];
            end
         end else if (step) begin
            if (cur_q[c] < tgt_q[c]) begin
               cur_d[c] = cur_q[c] + 8'd1;
            end else if (cur_q[c] > tgt_q[c]) begin
               cur_d[c] = cur_q[c] - 8'd1;
            end
         end
         led_d[c] = (pwm_cnt_q < cur_q[c]) ^ P_ACTIVE_LOW;
      end

      busy_d   = (cur_d != tgt_d);
      period_d = boundary;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         presc_q     <= '0;
         pwm_cnt_q   <= '0;
         fdiv_q      <= '0;
         pend_vld_q  <= 1'b0;
         pend_rgb_q  <= '0;
         pend_fade_q <= 1'b0;
         cur_q       <= '0;
         tgt_q       <= '0;
         led_q       <= {3{P_ACTIVE_LOW}};
         busy_q      <= 1'b0;
         period_q    <= 1'b0;
      end else begin
         presc_q     <= presc_d;
         pwm_cnt_q   <= pwm_cnt_d;
         fdiv_q      <= fdiv_d;
         pend_vld_q  <= pend_vld_d;
         pend_rgb_q  <= pend_rgb_d;
         pend_fade_q <= pend_fade_d;
         cur_q       <= cur_d;
         tgt_q       <= tgt_d;
         led_q       <= led_d;
         busy_q      <= busy_d;
         period_q    <= period_d;
      end
   end

   assign o_led_r  = led_q[0];
   assign o_led_g  = led_q[1];
   assign o_led_b  = led_q[2];
   assign o_busy   = busy_q;
   assign o_period = period_q;

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Bench for rgb_pwm_fader: directed scenarios plus random traffic, every cycle compared to a time-based reference model.
module tb_rgb_pwm_fader;

   localparam int PS  = 2;
   localparam int FD  = 2;
   localparam int PER = 256 * PS;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [23:0] rgb;
   logic        fade;
   logic        ready;
   logic        led_r, led_g, led_b;
   logic        busy;
   logic        period;

   int vectors = 0;
   int fails   = 0;

   always #5 clk = ~clk;

   rgb_pwm_fader #(
      .P_PRESCALE  (PS),
      .P_FADE_DIV  (FD),
      .P_ACTIVE_LOW(1'b1)
   ) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_valid (valid),
      .o_ready (ready),
      .i_rgb   (rgb),
      .i_fade  (fade),
      .o_led_r (led_r),
      .o_led_g (led_g),
      .o_led_b (led_b),
      .o_busy  (busy),
      .o_period(period)
   );

   // Reference model: position in the period comes from elapsed cycles since reset.
   int          m_t;
   int          m_nb;
   int          m_cur [3];
   int          m_tgt [3];
   bit          m_pend;
   logic [23:0] m_prgb;
   bit          m_pfade;
   bit   [2:0]  m_led;
   bit          m_busy;
   bit          m_period;
   int          m_pos;
   bit          m_bnd;
   bit          m_acc;

   always @(posedge clk) begin
      if (rst) begin
         m_t = 0; m_nb = 0; m_pend = 0; m_led = 3'b111; m_busy = 0; m_period = 0;
         for (int c = 0; c < 3; c++) begin m_cur[c] = 0; m_tgt[c] = 0; end
      end else begin
         m_pos = (m_t / PS) % 256;
         m_bnd = (m_t % PER) == PER - 1;
         for (int c = 0; c < 3; c++) m_led[c] = !(m_pos < m_cur[c]);
         m_period = m_bnd;
         m_acc = valid && !m_pend;
         if (m_bnd) begin
            if (m_pend) begin
               for (int c = 0; c < 3; c++) begin
                  m_tgt[c] = int'(m_prgb[8*(2-c) +: 8]);
                  if (!m_pfade) m_cur[c] = m_tgt[c];
               end
               m_pend = 0;
            end else if (m_nb % FD == FD - 1) begin
               for (int c = 0; c < 3; c++) begin
                  if (m_cur[c] < m_tgt[c]) m_cur[c] = m_cur[c] + 1;
                  else if (m_cur[c] > m_tgt[c]) m_cur[c] = m_cur[c] - 1;
               end
            end
            m_nb = m_nb + 1;
         end
         if (m_acc) begin
            m_pend = 1; m_prgb = rgb; m_pfade = fade;
         end
         m_busy = 0;
         for (int c = 0; c < 3; c++) if (m_cur[c] != m_tgt[c]) m_busy = 1;
         m_t = m_t + 1;
      end
   end

   wire [5:0] obs   = {led_r, led_g, led_b, ready, busy, period};
   wire [5:0] exp_o = {m_led[0], m_led[1], m_led[2], ~rst & ~m_pend, m_busy, m_period};

   // Red level seen in the retarget scenario during the period following boundary p.
   function automatic int exp_cur(input int p);
      if (p <= 10) return (p + 1) / 2;
      return (5 - (p - 11) / 2 < 2) ? 2 : 5 - (p - 11) / 2;
   endfunction

   task automatic test_reset();
      int last;
      int pulses;
      rst = 1'b1; valid = 1'b0; rgb = '0; fade = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if ({led_r, led_g, led_b, ready, busy} !== 5'b11100) begin
            fails++; $display("FAIL reset_hold dut=%b want=11100", {led_r, led_g, led_b, ready, busy});
         end
      end
      rst = 1'b0;
      last = -1; pulses = 0;
      for (int i = 0; i < 1100; i++) begin
         @(negedge clk);
         vectors++; if (obs !== exp_o) begin fails++; if (fails < 40) $display("FAIL model_reset t=%0t dut=%b model=%b", $time, obs, exp_o); end
         if (i == 0) begin
            vectors++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready_after dut=%b want=1", ready); end
         end
         if (period === 1'b1) begin
            vectors++;
            if ((i % PER) != PER - 1) begin fails++; $display("FAIL reset_period_phase cycle=%0d want=%0d", i, PER - 1 + pulses * PER); end
            last = i; pulses++;
         end
      end
      vectors++; if (pulses != 2) begin fails++; $display("FAIL reset_period_count dut=%0d want=2 last=%0d", pulses, last); end
   endtask

   task automatic test_jump();
      bit found;
      int lr, lg, lb;
      valid = 1'b1; rgb = 24'h8000FF; fade = 1'b0;
      @(negedge clk);
      vectors++; if (obs !== exp_o) begin fails++; if (fails < 40) $display("FAIL model_jump t=%0t dut=%b model=%b", $time, obs, exp_o); end
      valid = 1'b0; rgb = $urandom; fade = 1'b1;
      found = 0;
      for (int i = 0; i < PER + 8; i++) begin
         @(negedge clk);
         vectors++; if (obs !== exp_o) begin fails++; if (fails < 40) $display("FAIL model_jump t=%0t dut=%b model=%b", $time, obs, exp_o); end
         vectors++; if (busy !== 1'b0) begin fails++; $display("FAIL jump_busy dut=%b want=0", busy); end
         if (period === 1'b1) begin found = 1; break; end
         vectors++; if (ready !== 1'b0) begin fails++; $display("FAIL jump_ready_pending dut=%b want=0", ready); end
      end
      vectors++; if (!found) begin fails++; $display("FAIL jump_apply_timeout dut=no_pulse want=pulse"); end
      vectors++; if (ready !== 1'b1) begin fails++; $display("FAIL jump_ready_after_apply dut=%b want=1", ready); end
      lr = 0; lg = 0; lb = 0;
      for (int i = 0; i < PER; i++) begin
         @(negedge clk);
         vectors++; if (obs !== exp_o) begin fails++; if (fails < 40) $display("FAIL model_jump t=%0t dut=%b model=%b", $time, obs, exp_o); end
         if (!led_r) lr++;
         if (!led_g) lg++;
         if (!led_b) lb++;
         vectors++; if (busy !== 1'b0) begin fails++; $display("FAIL jump_busy dut=%b want=0", busy); end
      end
      vectors++; if (lr != 256) begin fails++; $display("FAIL jump_red_on dut=%0d want=256", lr); end
      vectors++; if (lg != 0)   begin fails++; $display("FAIL jump_green_on dut=%0d want=0", lg); end
      vectors++; if (lb != 510) begin fails++; $display("FAIL jump_blue_on dut=%0d want=510", lb); end
   endtask

   task automatic test_fade_up();
      bit found;
      int lows;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; valid = 1'b1; rgb = 24'h040000; fade = 1'b1;
      @(negedge clk);
      vectors++; if (obs !== exp_o) begin fails++; if (fails < 40) $display("FAIL model_fade t=%0t dut=%b model=%b", $time, obs, exp_o); end
      valid = 1'b0;
      found = 0;
      for (int i = 0; i < PER + 8; i++) begin
         @(negedge clk);
         vectors++; if (obs !== exp_o) begin fails++; if (fails < 40) $display("FAIL model_fade t=%0t dut=%b model=%b", $time, obs, exp_o); end
         if (period === 1'b1) begin found = 1; break; end
      end
      vectors++; if (!found) begin fails++; $display("FAIL fade_apply_timeout dut=no_pulse want=pulse"); end
      vectors++; if (busy !== 1'b1) begin fails++; $display("FAIL fade_busy_after_apply dut=%b want=1", busy); end
      for (int k = 0; k < 9; k++) begin
         lows = 0;
         for (int i = 0; i < PER; i++) begin
            @(negedge clk);
            vectors++; if (obs !== exp_o) begin fails++; if (fails < 40) $display("FAIL model_fade t=%0t dut=%b model=%b", $time, obs, exp_o); end
            if (!led_r) lows++;
         end
         vectors++; if (lows != 2 * ((k + 1) / 2)) begin fails++; $display("FAIL fade_red_on period=%0d dut=%0d want=%0d", k, lows, 2 * ((k + 1) / 2)); end
         vectors++; if (busy !== (k + 1 < 7)) begin fails++; $display("FAIL fade_busy period=%0d dut=%b want=%b", k + 1, busy, (k + 1 < 7)); end
      end
   endtask

   task automatic test_backpressure();
      bit found;
      int hold;
      int lr, lg, lb;
      valid = 1'b1; rgb = 24'h000000; fade = 1'b0;
      @(negedge clk);
      vectors++; if (ready !== 1'b0) begin fails++; $display("FAIL bp_slot_full dut=%b want=0", ready); end
      rgb = 24'h112233;
      hold = $urandom_range(10, 300);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         vectors++; if (obs !== exp_o) begin fails++; if (fails < 40) $display("FAIL model_bp t=%0t dut=%b model=%b", $time, obs, exp_o); end
      end
      rgb = 24'hFFFFFF;
      found = 0;
      for (int i = 0; i < PER + 8; i++) begin
         @(negedge clk);
         vectors++; if (obs !== exp_o) begin fails++; if (fails < 40) $display("FAIL model_bp t=%0t dut=%b model=%b", $time, obs, exp_o); end
         if (period === 1'b1) begin found = 1; break; end
      end
      vectors++; if (!found || ready !== 1'b1) begin fails++; $display("FAIL bp_ready_rise found=%0d dut=%b want=1", found, ready); end
      @(negedge clk);
      vectors++; if (ready !== 1'b0) begin fails++; $display("FAIL bp_captured dut=%b want=0", ready); end
      valid = 1'b0; rgb = 24'h112233;
      found = 0;
      for (int i = 0; i < PER + 8; i++) begin
         @(negedge clk);
         vectors++; if (obs !== exp_o) begin fails++; if (fails < 40) $display("FAIL model_bp t=%0t dut=%b model=%b", $time, obs, exp_o); end
         if (period === 1'b1) begin found = 1; break; end
      end
      vectors++; if (!found) begin fails++; $display("FAIL bp_apply_timeout dut=no_pulse want=pulse"); end
      lr = 0; lg = 0; lb = 0;
      for (int i = 0; i < PER; i++) begin
         @(negedge clk);
         vectors++; if (obs !== exp_o) begin fails++; if (fails < 40) $display("FAIL model_bp t=%0t dut=%b model=%b", $time, obs, exp_o); end
         if (!led_r) lr++;
         if (!led_g) lg++;
         if (!led_b) lb++;
      end
      vectors++; if (lr != 510 || lg != 510 || lb != 510) begin fails++; $display("FAIL bp_levels dut=%0d/%0d/%0d want=510/510/510", lr, lg, lb); end
   endtask

   task automatic test_retarget();
      bit found;
      int lows;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; valid = 1'b1; rgb = 24'h0A0000; fade = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      found = 0;
      for (int i = 0; i < PER + 8; i++) begin
         @(negedge clk);
         vectors++; if (obs !== exp_o) begin fails++; if (fails < 40) $display("FAIL model_retarget t=%0t dut=%b model=%b", $time, obs, exp_o); end
         if (period === 1'b1) begin found = 1; break; end
      end
      vectors++; if (!found) begin fails++; $display("FAIL retarget_apply_timeout dut=no_pulse want=pulse"); end
      for (int k = 0; k < 18; k++) begin
         if (k == 10) begin valid = 1'b1; rgb = 24'h020000; fade = 1'b1; end
         lows = 0;
         for (int i = 0; i < PER; i++) begin
            @(negedge clk);
            vectors++; if (obs !== exp_o) begin fails++; if (fails < 40) $display("FAIL model_retarget t=%0t dut=%b model=%b", $time, obs, exp_o); end
            if (i == 0) valid = 1'b0;
            if (!led_r) lows++;
         end
         vectors++; if (lows != 2 * exp_cur(k)) begin fails++; $display("FAIL retarget_red_on period=%0d dut=%0d want=%0d", k, lows, 2 * exp_cur(k)); end
         vectors++;
         if (busy !== (exp_cur(k + 1) != ((k + 1 <= 10) ? 10 : 2))) begin
            fails++; $display("FAIL retarget_busy period=%0d dut=%b", k + 1, busy);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit found;
      int wait_n;
      valid = 1'b1; rgb = 24'h800000; fade = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      found = 0;
      for (int i = 0; i < PER + 8; i++) begin
         @(negedge clk);
         vectors++; if (obs !== exp_o) begin fails++; if (fails < 40) $display("FAIL model_rstmid t=%0t dut=%b model=%b", $time, obs, exp_o); end
         if (period === 1'b1) begin found = 1; break; end
      end
      vectors++; if (!found || busy !== 1'b1) begin fails++; $display("FAIL rstmid_busy found=%0d dut=%b want=1", found, busy); end
      valid = 1'b1; rgb = 24'h00FF00; fade = 1'b0;
      @(negedge clk);
      valid = 1'b0;
      vectors++; if (ready !== 1'b0) begin fails++; $display("FAIL rstmid_pending dut=%b want=0", ready); end
      wait_n = $urandom_range(5, 200);
      for (int i = 0; i < wait_n; i++) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      vectors++;
      if ({led_r, led_g, led_b, ready, busy} !== 5'b11100) begin
         fails++; $display("FAIL rstmid_outputs dut=%b want=11100", {led_r, led_g, led_b, ready, busy});
      end
      rst = 1'b0;
      for (int i = 0; i < 2 * PER + 16; i++) begin
         @(negedge clk);
         vectors++; if (obs !== exp_o) begin fails++; if (fails < 40) $display("FAIL model_rstmid t=%0t dut=%b model=%b", $time, obs, exp_o); end
         vectors++; if ({led_r, led_g, led_b, busy} !== 4'b1110) begin fails++; if (fails < 40) $display("FAIL rstmid_dark dut=%b want=1110", {led_r, led_g, led_b, busy}); end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         vectors++; if (obs !== exp_o) begin fails++; if (fails < 40) $display("FAIL model_random t=%0t dut=%b model=%b", $time, obs, exp_o); end
         valid = ($urandom_range(0, 3) == 0);
         rgb   = $urandom;
         fade  = $urandom_range(0, 1);
         rst   = ($urandom_range(0, 2999) == 0);
      end
      valid = 1'b0; rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; valid = 1'b0; rgb = '0; fade = 1'b0;
      test_reset();
      test_jump();
      test_fade_up();
      test_backpressure();
      test_retarget();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog_timeout t=%0t want=finish", $time);
      $fatal(1, "watchdog");
   end

endmodule
